// File: rtl/uart_rx.sv
// 8n1 UART receiver with OVS-times oversampling.
// The serial input is double-flopped. A single FSM checks the start bit at
// mid-bit, samples 8 data bits LSB first and checks the stop bit. Good bytes
// raise a one-cycle data_rdy strobe. A low stop bit raises a one-cycle
// frame_err strobe, discards the byte and waits in BREAK for the line to
// return high.
module uart_rx #(
   parameter int OVS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   output logic [7:0] data,
   output logic       data_rdy,
   output logic       frame_err,
   output logic       busy
);

   localparam int PW = $clog2(OVS);
   localparam logic [PW-1:0] PH_MID = PW'(OVS / 2 - 1);
   localparam logic [PW-1:0] PH_END = PW'(OVS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   logic          sync1_q;
   logic          sync2_q;
   state_t        state_q;
   logic [PW-1:0] phase_q;
   logic [2:0]    bitcnt_q;
   logic [7:0]    shift_q;
   logic [7:0]    data_q;
   logic          data_rdy_q;
   logic          frame_err_q;
   logic          busy_q;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
      end
   end

   // Frame FSM: phase counting, bit sampling and registered output strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         bitcnt_q    <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         data_rdy_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         data_rdy_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               phase_q <= '0;
               if (!sync2_q) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            START: begin
               if (phase_q == PH_MID) begin
                  phase_q <= '0;
                  if (sync2_q) begin
                     // False start: the line went back high before mid-bit.
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q  <= DATA;
                     bitcnt_q <= 3'd0;
                  end
               end else begin
                  phase_q <= phase_q + PW'(1);
               end
            end
            DATA: begin
               if (phase_q == PH_END) begin
                  phase_q <= '0;
                  shift_q <= {sync2_q, shift_q[7:1]};
                  if (bitcnt_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bitcnt_q <= bitcnt_q + 3'd1;
                  end
               end else begin
                  phase_q <= phase_q + PW'(1);
               end
            end
            STOP: begin
               if (phase_q == PH_END) begin
                  phase_q <= '0;
                  if (sync2_q) begin
                     // Leave at mid-stop-bit so a following start edge is caught.
                     data_q     <= shift_q;
                     data_rdy_q <= 1'b1;
                     state_q    <= IDLE;
                     busy_q     <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BRK;
                  end
               end else begin
                  phase_q <= phase_q + PW'(1);
               end
            end
            BRK: begin
               phase_q <= '0;
               if (sync2_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               phase_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data      = data_q;
   assign data_rdy  = data_rdy_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus pushes expected strobes
// (kind, byte, cycle) into a queue; a monitor pops and compares on every
// data_rdy or frame_err pulse.
module tb_uart_rx;

   localparam int OVS  = 16;
   localparam int LAT  = 2 + 9 * OVS + OVS / 2 + 1;   // drive cycle -> strobe cycle

   typedef struct packed {
      logic        is_err;
      logic [7:0]  d;
      logic [31:0] at;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       data_rdy;
   logic       frame_err;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         busy_cnt = 0;
   exp_t       sb[$];
   logic [7:0] model_data = 8'h00;

   uart_rx #(.OVS(OVS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (rx),
      .data      (data),
      .data_rdy  (data_rdy),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drives one 8n1 frame starting at the current negedge and books the expected strobe.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      int n0;
      n0 = cyc;
      if (stop) begin
         sb.push_back('{is_err: 1'b0, d: b, at: 32'(n0 + LAT)});
         model_data = b;
      end else begin
         sb.push_back('{is_err: 1'b1, d: model_data, at: 32'(n0 + LAT)});
      end
      rx = 1'b0;
      repeat (OVS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (OVS) @(negedge clk);
      end
      rx = stop;
      repeat (OVS) @(negedge clk);
   endtask

   initial begin
      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (!rst) begin
                  if (busy === 1'b1) busy_cnt++;
                  if (data_rdy === 1'b1 || frame_err === 1'b1) begin
                     if (data_rdy === 1'b1 && frame_err === 1'b1)
                        chk("rdy_err_overlap", 32'd1, 32'd0);
                     if (sb.size() == 0) begin
                        chk("unexpected_strobe", {30'd0, data_rdy, frame_err}, 32'd0);
                     end else begin
                        e = sb.pop_front();
                        chk("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                        chk("strobe_cycle", 32'(cyc), e.at);
                        chk("strobe_data", {24'd0, data}, {24'd0, e.d});
                     end
                  end
               end
            end
         end
         begin : stimulus
            int b0;
            // Reset values
            repeat (2) @(negedge clk);
            chk("rst_data", {24'd0, data}, 32'h00);
            chk("rst_rdy", {31'd0, data_rdy}, 32'd0);
            chk("rst_err", {31'd0, frame_err}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            rst = 1'b0;
            repeat (3) @(negedge clk);

            // Idle line with a reset pulse: nothing happens for 1000 cycles
            b0 = busy_cnt;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (1000) @(negedge clk);
            chk("idle_data", {24'd0, data}, 32'h00);
            chk("idle_busy_cnt", 32'(busy_cnt - b0), 32'd0);

            // Single frame 0xA5
            b0 = busy_cnt;
            send_frame(8'hA5, 1'b1);
            repeat (40) @(negedge clk);
            chk("a5_sb_empty", 32'(sb.size()), 32'd0);
            chk("a5_data", {24'd0, data}, 32'hA5);
            chk("a5_busy_cnt", 32'(busy_cnt - b0), 32'd152);

            // Back-to-back 0x00 then 0xFF
            b0 = busy_cnt;
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
            repeat (40) @(negedge clk);
            chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
            chk("b2b_data", {24'd0, data}, 32'hFF);
            chk("b2b_busy_cnt", 32'(busy_cnt - b0), 32'd304);

            // 5-cycle glitch: false start
            b0 = busy_cnt;
            rx = 1'b0;
            repeat (5) @(negedge clk);
            rx = 1'b1;
            repeat (40) @(negedge clk);
            chk("glitch_busy_cnt", 32'(busy_cnt - b0), 32'd8);
            chk("glitch_data", {24'd0, data}, 32'hFF);
            chk("glitch_busy", {31'd0, busy}, 32'd0);

            // 0x3C with low stop bit, then line held low 40 bit-times
            b0 = busy_cnt;
            send_frame(8'h3C, 1'b0);
            rx = 1'b0;
            repeat (40 * OVS) @(negedge clk);
            chk("break_busy_held", {31'd0, busy}, 32'd1);
            rx = 1'b1;
            repeat (40) @(negedge clk);
            chk("break_sb_empty", 32'(sb.size()), 32'd0);
            chk("break_data", {24'd0, data}, 32'hFF);
            chk("break_busy_cnt", 32'(busy_cnt - b0), 32'd800);
            chk("break_busy_end", {31'd0, busy}, 32'd0);

            // Reset in the middle of data bit 4 of 0x81
            rx = 1'b0;                                   // start bit
            repeat (OVS) @(negedge clk);
            rx = 1'b1;                                   // bit 0
            repeat (OVS) @(negedge clk);
            rx = 1'b0;                                   // bits 1..3, half of bit 4
            repeat (3 * OVS + OVS / 2) @(negedge clk);
            chk("abort_busy_pre", {31'd0, busy}, 32'd1);
            rst = 1'b1;
            #1;
            chk("abort_busy_async", {31'd0, busy}, 32'd0);
            chk("abort_data_async", {24'd0, data}, 32'h00);
            model_data = 8'h00;
            rx = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (40) @(negedge clk);
            chk("abort_data_after", {24'd0, data}, 32'h00);
            chk("abort_busy_after", {31'd0, busy}, 32'd0);
            send_frame(8'h81, 1'b1);
            repeat (40) @(negedge clk);
            chk("clean81_sb_empty", 32'(sb.size()), 32'd0);
            chk("clean81_data", {24'd0, data}, 32'h81);
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
